// File: rtl/div_sequencer_if.sv
// Operand, divider, keypad and display signals shared by the divide sequencer and its surroundings.
// No storage: pure wiring bundle, zero latency.
// Backpressure is carried by op_ready (driven by the sequencer, honoured by the operand source).
`timescale 1ns/1ps
interface div_sequencer_if #(
  parameter int N = 16
) ();
  // operand entry handshake
  logic         op_valid;
  logic         op_ready;
  logic [N-1:0] op_A;
  logic [N-1:0] op_B;
  logic         op_sign_A;
  logic         op_sign_B;
  // divider request / response
  logic         div_start;
  logic [N-1:0] div_A;
  logic [N-1:0] div_B;
  logic         div_sign_A;
  logic         div_sign_B;
  logic         div_done;
  logic [N-1:0] div_Q;
  logic [N-1:0] div_R;
  logic         div_sign_Q;
  logic         div_sign_R;
  logic         div_err0;
  // keypad
  logic         key_valid;
  logic [3:0]   key_code;
  // display and status
  logic [N-1:0] disp_val;
  logic         disp_neg;
  logic         disp_sel;
  logic         busy;
  logic         err;
  logic [1:0]   err_code;

  // sequencer side
  modport slave (
    input  op_valid, op_A, op_B, op_sign_A, op_sign_B,
    output op_ready,
    output div_start, div_A, div_B, div_sign_A, div_sign_B,
    input  div_done, div_Q, div_R, div_sign_Q, div_sign_R, div_err0,
    input  key_valid, key_code,
    output disp_val, disp_neg, disp_sel, busy, err, err_code
  );

  // environment side: operand source, divider, keypad, display
  modport master (
    output op_valid, op_A, op_B, op_sign_A, op_sign_B,
    input  op_ready,
    input  div_start, div_A, div_B, div_sign_A, div_sign_B,
    output div_done, div_Q, div_R, div_sign_Q, div_sign_R, div_err0,
    output key_valid, key_code,
    input  disp_val, disp_neg, disp_sel, busy, err, err_code
  );
endinterface

// File: rtl/div_sequencer.sv
// Sequences one divide: captures operands, pulses the divider, latches Q/R for display, handles keys and errors.
// Latency: capture edge k -> div_start in cycle k+1; result on disp_val the cycle after div_done is sampled.
// Backpressure: op_ready low in ISSUE/WAIT; operands offered then are dropped, not queued.
`timescale 1ns/1ps
module div_sequencer #(
  parameter int         N        = 16,
  parameter int         TIMEOUT  = 64,
  parameter logic [3:0] KEY_SWAP = 4'hE,
  parameter logic [3:0] KEY_CLR  = 4'hF
) (
  input logic            clk,
  input logic            rst,
  div_sequencer_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESULT,
    S_ERROR
  } state_t;

  state_t        state;
  logic          op_ready_q;
  logic          div_start_q;
  logic          busy_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [N-1:0]  disp_val_q;
  logic          disp_neg_q;
  logic          disp_sel_q;
  logic [N-1:0]  div_a_q;
  logic [N-1:0]  div_b_q;
  logic          div_sign_a_q;
  logic          div_sign_b_q;
  logic [N-1:0]  q_lat;
  logic [N-1:0]  r_lat;
  logic          sq_lat;
  logic          sr_lat;
  logic [CW-1:0] cnt;

  logic capture;
  logic key_clr;
  logic key_swap;
  logic timeout_hit;

  assign capture     = bus.op_valid & op_ready_q;
  assign key_clr     = bus.key_valid && (bus.key_code == KEY_CLR);
  assign key_swap    = bus.key_valid && (bus.key_code == KEY_SWAP);
  assign timeout_hit = (cnt == CW'(TIMEOUT));

  // Main sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      op_ready_q   <= 1'b1;
      div_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      disp_val_q   <= '0;
      disp_neg_q   <= 1'b0;
      disp_sel_q   <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_sign_a_q <= 1'b0;
      div_sign_b_q <= 1'b0;
      q_lat        <= '0;
      r_lat        <= '0;
      sq_lat       <= 1'b0;
      sr_lat       <= 1'b0;
      cnt          <= '0;
    end else begin
      div_start_q <= 1'b0;
      case (state)
        S_IDLE, S_RESULT, S_ERROR: begin
          if (capture) begin
            // a new capture outranks any key in the same cycle
            div_a_q      <= bus.op_A;
            div_b_q      <= bus.op_B;
            div_sign_a_q <= bus.op_sign_A;
            div_sign_b_q <= bus.op_sign_B;
            disp_sel_q   <= 1'b0;
            disp_val_q   <= '0;
            disp_neg_q   <= 1'b0;
            if (bus.op_B != '0) begin
              state       <= S_ISSUE;
              op_ready_q  <= 1'b0;
              div_start_q <= 1'b1;
              busy_q      <= 1'b1;
              err_q       <= 1'b0;
              err_code_q  <= 2'b00;
            end else begin
              // divide-by-zero caught locally; the divider is never started
              state      <= S_ERROR;
              op_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
            end
          end else if ((state != S_IDLE) && key_clr) begin
            state      <= S_IDLE;
            q_lat      <= '0;
            r_lat      <= '0;
            sq_lat     <= 1'b0;
            sr_lat     <= 1'b0;
            disp_val_q <= '0;
            disp_neg_q <= 1'b0;
            disp_sel_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
          end else if ((state == S_RESULT) && key_swap) begin
            // flip the view and load the value matching the new selection
            disp_sel_q <= ~disp_sel_q;
            disp_val_q <= disp_sel_q ? q_lat : r_lat;
            disp_neg_q <= disp_sel_q ? sq_lat : sr_lat;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
          cnt   <= CW'(1);
        end

        S_WAIT: begin
          if (bus.div_done) begin
            // done wins even on the timeout cycle
            cnt        <= '0;
            busy_q     <= 1'b0;
            op_ready_q <= 1'b1;
            if (bus.div_err0) begin
              state      <= S_ERROR;
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
            end else begin
              state      <= S_RESULT;
              q_lat      <= bus.div_Q;
              r_lat      <= bus.div_R;
              sq_lat     <= bus.div_sign_Q;
              sr_lat     <= bus.div_sign_R;
              disp_val_q <= bus.div_Q;
              disp_neg_q <= bus.div_sign_Q;
            end
          end else if (timeout_hit) begin
            state      <= S_ERROR;
            cnt        <= '0;
            busy_q     <= 1'b0;
            op_ready_q <= 1'b1;
            err_q      <= 1'b1;
            err_code_q <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          op_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready   = op_ready_q;
  assign bus.div_start  = div_start_q;
  assign bus.div_A      = div_a_q;
  assign bus.div_B      = div_b_q;
  assign bus.div_sign_A = div_sign_a_q;
  assign bus.div_sign_B = div_sign_b_q;
  assign bus.disp_val   = disp_val_q;
  assign bus.disp_neg   = disp_neg_q;
  assign bus.disp_sel   = disp_sel_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: table of operand/divider-response records plus hand-written corner sequences.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// The bench plays the divider, counting start pulses and busy cycles per operation.
`timescale 1ns/1ps
module tb_div_sequencer;

  localparam int         N        = 16;
  localparam int         TIMEOUT  = 64;
  localparam logic [3:0] KEY_SWAP = 4'hE;
  localparam logic [3:0] KEY_CLR  = 4'hF;
  localparam int         NVEC     = 7;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_sequencer_if #(.N(N)) bus ();

  div_sequencer #(
    .N        (N),
    .TIMEOUT  (TIMEOUT),
    .KEY_SWAP (KEY_SWAP),
    .KEY_CLR  (KEY_CLR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sa;
    logic        sb;
    logic [15:0] q;
    logic [15:0] r;
    logic        sq;
    logic        sr;
    logic        e0;
    int          lat;          // WAIT cycle on which done is returned, 0 = never
    int          exp_starts;
    int          exp_busy;
    logic [15:0] exp_val;
    logic        exp_neg;
    logic [15:0] exp_swap_val;
    logic        exp_swap_neg;
    logic        exp_swap_sel;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t v;
  int   starts;
  int   busy_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic sa, input logic sb);
    bus.op_A      = a;
    bus.op_B      = b;
    bus.op_sign_A = sa;
    bus.op_sign_B = sb;
    bus.op_valid  = 1'b1;
  endtask

  task automatic return_done(input logic [15:0] q, input logic [15:0] r, input logic sq,
                             input logic sr, input logic e0);
    bus.div_Q      = q;
    bus.div_R      = r;
    bus.div_sign_Q = sq;
    bus.div_sign_R = sr;
    bus.div_err0   = e0;
    bus.div_done   = 1'b1;
    tick();
    bus.div_done   = 1'b0;
    bus.div_err0   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          a        b      sa    sb    q        r      sq    sr    e0   lat st busy val      neg   swapval swneg swsel err   code
    vecs[0] = '{16'd100, 16'd7, 1'b0, 1'b0, 16'd14,  16'd2, 1'b0, 1'b0, 1'b0, 5, 1, 6,  16'd14,  1'b0, 16'd2, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[1] = '{16'd45,  16'd6, 1'b1, 1'b0, 16'd7,   16'd3, 1'b1, 1'b1, 1'b0, 3, 1, 4,  16'd7,   1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 2'b00};
    vecs[2] = '{16'd5,   16'd0, 1'b0, 1'b0, 16'd0,   16'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0,  16'd0,   1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[3] = '{16'd1000,16'd10,1'b0, 1'b0, 16'd100, 16'd0, 1'b0, 1'b0, 1'b0, 0, 1, 65, 16'd0,   1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[4] = '{16'd1000,16'd10,1'b0, 1'b0, 16'd100, 16'd0, 1'b0, 1'b0, 1'b0, 64,1, 65, 16'd100, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[5] = '{16'd3,   16'd1, 1'b0, 1'b0, 16'd0,   16'd0, 1'b0, 1'b0, 1'b1, 2, 1, 3,  16'd0,   1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[6] = '{16'hFFFF,16'd1, 1'b0, 1'b1, 16'hFFFF,16'd0, 1'b1, 1'b0, 1'b0, 1, 1, 2,  16'hFFFF,1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 2'b00};

    rst            = 1'b0;
    bus.op_valid   = 1'b0;
    bus.op_A       = '0;
    bus.op_B       = '0;
    bus.op_sign_A  = 1'b0;
    bus.op_sign_B  = 1'b0;
    bus.div_done   = 1'b0;
    bus.div_Q      = '0;
    bus.div_R      = '0;
    bus.div_sign_Q = 1'b0;
    bus.div_sign_R = 1'b0;
    bus.div_err0   = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;

    // reset state
    repeat (2) tick();
    check("rst_op_ready",  bus.op_ready,   1);
    check("rst_div_start", bus.div_start,  0);
    check("rst_busy",      bus.busy,       0);
    check("rst_err",       bus.err,        0);
    check("rst_err_code",  bus.err_code,   0);
    check("rst_disp_val",  bus.disp_val,   0);
    check("rst_disp_neg",  bus.disp_neg,   0);
    check("rst_disp_sel",  bus.disp_sel,   0);
    check("rst_div_A",     bus.div_A,      0);
    check("rst_div_B",     bus.div_B,      0);
    rst = 1'b1;
    tick();

    // table-driven operations
    for (int k = 0; k < NVEC; k++) begin
      v = vecs[k];
      offer(v.a, v.b, v.sa, v.sb);
      tick();
      bus.op_valid = 1'b0;
      check("cap_div_A",      bus.div_A,      v.a);
      check("cap_div_sign_A", bus.div_sign_A, v.sa);
      check("cap_div_sign_B", bus.div_sign_B, v.sb);
      starts = 0;
      busy_n = 0;
      for (int i = 0; i < 200; i++) begin
        if (bus.div_start) starts++;
        if (bus.busy) busy_n++;
        if (!bus.busy) break;
        bus.div_Q      = v.q;
        bus.div_R      = v.r;
        bus.div_sign_Q = v.sq;
        bus.div_sign_R = v.sr;
        bus.div_err0   = v.e0;
        bus.div_done   = (v.lat > 0) && (i == v.lat);
        // operands offered while busy must be dropped
        bus.op_valid   = (i == 2);
        bus.op_A       = 16'h1234;
        bus.op_B       = 16'h0000;
        tick();
        bus.div_done   = 1'b0;
        bus.op_valid   = 1'b0;
      end
      check("starts",       starts,        v.exp_starts);
      check("busy_cycles",  busy_n,        v.exp_busy);
      check("hold_div_A",   bus.div_A,     v.a);
      check("res_disp_val", bus.disp_val,  v.exp_val);
      check("res_disp_neg", bus.disp_neg,  v.exp_neg);
      check("res_disp_sel", bus.disp_sel,  0);
      check("res_err",      bus.err,       v.exp_err);
      check("res_err_code", bus.err_code,  v.exp_code);
      check("res_op_ready", bus.op_ready,  1);

      press(4'h3);
      check("other_key_val", bus.disp_val, v.exp_val);

      press(KEY_SWAP);
      check("swap_val", bus.disp_val, v.exp_swap_val);
      check("swap_neg", bus.disp_neg, v.exp_swap_neg);
      check("swap_sel", bus.disp_sel, v.exp_swap_sel);
      check("swap_err", bus.err,      v.exp_err);

      press(KEY_CLR);
      check("clr_disp_val", bus.disp_val, 0);
      check("clr_disp_neg", bus.disp_neg, 0);
      check("clr_err",      bus.err,      0);
      check("clr_err_code", bus.err_code, 0);
      check("clr_op_ready", bus.op_ready, 1);

      // a stray done in IDLE has no effect
      return_done(16'h5555, 16'h0AAA, 1'b1, 1'b1, 1'b0);
      check("stray_done_val",  bus.disp_val, 0);
      check("stray_done_busy", bus.busy,     0);
    end

    // reset asserted mid-WAIT, then a late done
    offer(16'd50, 16'd5, 1'b0, 1'b0);
    tick();
    bus.op_valid = 1'b0;
    tick();
    tick();
    check("mid_wait_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_busy",     bus.busy,     0);
    check("async_rst_op_ready", bus.op_ready, 1);
    check("async_rst_div_A",    bus.div_A,    0);
    tick();
    rst = 1'b1;
    return_done(16'd10, 16'd0, 1'b0, 1'b0, 1'b0);
    check("late_done_val",      bus.disp_val, 0);
    check("late_done_busy",     bus.busy,     0);
    check("late_done_err",      bus.err,      0);
    check("late_done_op_ready", bus.op_ready, 1);
    tick();

    // capture on the first edge after reset release
    rst = 1'b0;
    tick();
    rst = 1'b1;
    offer(16'd9, 16'd3, 1'b0, 1'b0);
    tick();
    bus.op_valid = 1'b0;
    check("first_edge_start", bus.div_start, 1);
    tick();
    return_done(16'd3, 16'd0, 1'b0, 1'b0, 1'b0);
    check("first_edge_val", bus.disp_val, 3);
    press(KEY_SWAP);
    check("pre_clash_sel", bus.disp_sel, 1);

    // capture and KEY_CLR in the same RESULT cycle: capture wins
    offer(16'd9, 16'd3, 1'b0, 1'b0);
    bus.key_valid = 1'b1;
    bus.key_code  = KEY_CLR;
    tick();
    bus.op_valid  = 1'b0;
    bus.key_valid = 1'b0;
    check("clash_div_start", bus.div_start, 1);
    check("clash_div_A",     bus.div_A,     9);
    check("clash_disp_sel",  bus.disp_sel,  0);
    check("clash_busy",      bus.busy,      1);
    check("clash_op_ready",  bus.op_ready,  0);
    tick();
    check("clash_single_pulse", bus.div_start, 0);
    return_done(16'd3, 16'd0, 1'b0, 1'b0, 1'b0);
    check("clash_result_val", bus.disp_val, 3);
    check("clash_result_err", bus.err,      0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
